// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store sequencer and its bus.
package load_store_unit_pkg;
  localparam int unsigned WORD_SIZE = 19;
  localparam int unsigned DM_DEPTH  = 1024;
  localparam int unsigned DM_AW     = $clog2(DM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WR,
    ISSUE_RD,
    WAIT_RD,
    RESP
  } lsu_state_t;

  // Only in-range addresses are latched, so the memory index width suffices.
  typedef struct packed {
    logic                 we;
    logic [DM_AW-1:0]     addr;
    logic [WORD_SIZE-1:0] wdata;
  } lsu_req_t;
endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake bus between the execute stage and the LSU.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [WORD_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [WORD_SIZE-1:0] resp_rdata;
  logic                 resp_fault;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: accepts one request, range-checks it, drives the
// data memory and returns a single response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  load_store_unit_if.slave     bus,
  output logic                 o_dm_wr_en,
  output logic                 o_dm_rd_en,
  output logic [DM_AW-1:0]     o_dm_addr,
  output logic [WORD_SIZE-1:0] o_dm_wdata,
  input  logic [WORD_SIZE-1:0] i_dm_rdata,
  output logic [CNT_W-1:0]     o_fault_count
);

  lsu_state_t           r_state;
  lsu_state_t           w_next;
  lsu_req_t             r_req;
  logic [WORD_SIZE-1:0] r_resp_rdata;
  logic                 r_resp_fault;
  logic [CNT_W-1:0]     r_fault_count;
  logic                 w_accept;
  logic                 w_oor;

  assign w_oor         = bus.req_addr >= WORD_SIZE'(DM_DEPTH);
  assign bus.req_ready = (r_state == IDLE) && !i_rst;
  assign w_accept      = bus.req_valid && bus.req_ready;

  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_fault = r_resp_fault;
  assign o_fault_count  = r_fault_count;

  // Memory address/data come straight from the latched request; since only
  // in-range fields are latched they hold their last driven value otherwise.
  assign o_dm_addr  = r_req.addr;
  assign o_dm_wdata = r_req.wdata;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and memory strobes (strobes suppressed during reset).
  always_comb begin
    w_next     = r_state;
    o_dm_wr_en = 1'b0;
    o_dm_rd_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_oor)            w_next = RESP;
          else if (bus.req_we)  w_next = ISSUE_WR;
          else                  w_next = ISSUE_RD;
        end
      end
      ISSUE_WR: begin
        o_dm_wr_en = !i_rst && r_req.we;
        w_next     = RESP;
      end
      ISSUE_RD: begin
        o_dm_rd_en = !i_rst && !r_req.we;
        w_next     = WAIT_RD;
      end
      WAIT_RD: w_next = RESP;
      RESP: begin
        if (bus.resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request latch: address only when in range, data only for in-range stores.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req.we <= bus.req_we;
      if (!w_oor) begin
        r_req.addr <= bus.req_addr[DM_AW-1:0];
        if (bus.req_we) r_req.wdata <= bus.req_wdata;
      end
    end
  end

  // Response registers: cleared on acceptance, load data captured in WAIT_RD.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
    end else if (w_accept) begin
      r_resp_rdata <= '0;
      r_resp_fault <= w_oor;
    end else if (r_state == WAIT_RD) begin
      r_resp_rdata <= i_dm_rdata;
    end
  end

  // Saturating count of out-of-range requests.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fault_count <= '0;
    end else if (w_accept && w_oor && (r_fault_count != '1)) begin
      r_fault_count <= r_fault_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data memory.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 dm_wr_en;
  logic                 dm_rd_en;
  logic [DM_AW-1:0]     dm_addr;
  logic [WORD_SIZE-1:0] dm_wdata;
  logic [WORD_SIZE-1:0] dm_rdata;
  logic [15:0]          fault_count;

  load_store_unit_if bus ();

  load_store_unit #(.CNT_W(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus),
    .o_dm_wr_en    (dm_wr_en),
    .o_dm_rd_en    (dm_rd_en),
    .o_dm_addr     (dm_addr),
    .o_dm_wdata    (dm_wdata),
    .i_dm_rdata    (dm_rdata),
    .o_fault_count (fault_count)
  );

  always #5 clk = ~clk;

  // Data memory with registered read.
  logic [WORD_SIZE-1:0] mem [DM_DEPTH];
  always @(posedge clk) begin
    if (dm_wr_en) mem[dm_addr] <= dm_wdata;
    if (dm_rd_en) dm_rdata     <= mem[dm_addr];
  end

  // Strobe monitor.
  int                   wr_cnt = 0;
  int                   rd_cnt = 0;
  int                   both_cnt = 0;
  logic [DM_AW-1:0]     wr_addr_seen;
  logic [WORD_SIZE-1:0] wr_data_seen;
  logic [DM_AW-1:0]     rd_addr_seen;
  always @(posedge clk) begin
    if (dm_wr_en) begin
      wr_cnt++;
      wr_addr_seen = dm_addr;
      wr_data_seen = dm_wdata;
    end
    if (dm_rd_en) begin
      rd_cnt++;
      rd_addr_seen = dm_addr;
    end
    if (dm_wr_en && dm_rd_en) both_cnt++;
  end

  typedef struct {
    logic [WORD_SIZE-1:0] rdata;
    logic                 fault;
    int                   lat;
  } exp_t;

  exp_t                 sb_q [$];
  logic [WORD_SIZE-1:0] sb_mem [DM_DEPTH];
  int                   n_checks = 0;
  int                   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, hold the response for 'stall' cycles, then complete it.
  task automatic do_req(input logic we, input logic [WORD_SIZE-1:0] addr,
                        input logic [WORD_SIZE-1:0] wdata, input int stall);
    exp_t e;
    int   w0, r0, lat;
    logic oor;
    oor     = (addr >= 19'd1024);
    e.fault = oor;
    e.rdata = (we || oor) ? '0 : sb_mem[addr[9:0]];
    e.lat   = oor ? 1 : (we ? 2 : 3);
    if (we && !oor) sb_mem[addr[9:0]] = wdata;
    sb_q.push_back(e);
    w0 = wr_cnt;
    r0 = rd_cnt;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    check("resp_latency", lat, e.lat);
    check("resp_rdata", bus.resp_rdata, e.rdata);
    check("resp_fault", bus.resp_fault, e.fault);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("stall_valid", bus.resp_valid, 1);
      check("stall_rdata", bus.resp_rdata, e.rdata);
      check("stall_req_ready", bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("post_resp_valid", bus.resp_valid, 0);
    check("post_req_ready", bus.req_ready, 1);
    check("wr_pulses", wr_cnt - w0, (we && !oor) ? 1 : 0);
    check("rd_pulses", rd_cnt - r0, (!we && !oor) ? 1 : 0);
    if (we && !oor) begin
      check("wr_addr", wr_addr_seen, addr[9:0]);
      check("wr_data", wr_data_seen, wdata);
    end
    if (!we && !oor) check("rd_addr", rd_addr_seen, addr[9:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DM_DEPTH); i++) sb_mem[i] = '0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_dm_wr_en", dm_wr_en, 0);
    check("rst_dm_rd_en", dm_rd_en, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_fault_count", fault_count, 0);
    @(negedge clk);
    rst = 1'b0;

    do_req(1'b1, 19'd10, 19'h5A5A5, 0);
    do_req(1'b0, 19'd10, 19'h0, 0);
    do_req(1'b1, 19'd1023, 19'h7FFFF, 0);
    do_req(1'b0, 19'd1023, 19'h0, 0);
    do_req(1'b0, 19'd1024, 19'h0, 0);
    check("fault_count_1", fault_count, 1);
    do_req(1'b1, 19'h7FFFF, 19'h11111, 0);
    check("fault_count_2", fault_count, 2);
    check("no_alias_1023", mem[1023], 19'h7FFFF);
    do_req(1'b1, 19'd77, 19'h2468A, 0);
    do_req(1'b0, 19'd77, 19'h0, 5);

    // Reset while in ISSUE_WR: no write may reach the memory.
    begin
      int w0;
      w0 = wr_cnt;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 19'd1023;
      bus.req_wdata = 19'h00ABC;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("issue_wr_strobe", dm_wr_en, 1);
      rst = 1'b1;
      #1;
      check("rst_gates_wr", dm_wr_en, 0);
      check("rst_gates_ready", bus.req_ready, 0);
      @(posedge clk); #1;
      check("abort_resp_valid", bus.resp_valid, 0);
      check("abort_resp_rdata", bus.resp_rdata, 0);
      check("abort_resp_fault", bus.resp_fault, 0);
      check("abort_dm_addr", dm_addr, 0);
      check("abort_dm_wdata", dm_wdata, 0);
      check("abort_fault_count", fault_count, 0);
      check("abort_no_write", wr_cnt - w0, 0);
      @(negedge clk);
      rst = 1'b0;
    end
    do_req(1'b0, 19'd1023, 19'h0, 0);

    // Saturation of the fault counter.
    @(negedge clk);
    force dut.r_fault_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_fault_count;
    check("forced_count", fault_count, 16'hFFFF);
    do_req(1'b0, 19'd2000, 19'h0, 0);
    check("fault_count_sat", fault_count, 16'hFFFF);

    check("strobes_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
